fetch_redirect_unit: RTL and testbench

Fetch-stage PC register and IF/ID pipeline register for the five-stage MIPS datapath. Consumes the ID-stage `zero` result from the branch comparator, decodes beq/bne/j from the instruction it holds in IF/ID, and redirects the PC with a one-cycle penalty. Taken branches and jumps squash the wrong-path fetch. The block also honours the hazard unit's stall and counts redirects.

---
 rtl/fetch_redirect_unit_if.sv | 27 ++
 rtl/fetch_redirect_unit.sv | 102 ++++++++++
 tb/tb_fetch_redirect_unit.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_redirect_unit_if.sv
// Fetch-side bus of the fetch/redirect unit: hazard and comparator inputs,
// instruction memory data, and the PC / IF/ID outputs.
interface fetch_redirect_unit_if #(
  parameter int CNT_W = 16
);
  logic             stall;
  logic             zero;
  logic [31:0]      imem_instr;
  logic [31:0]      pc;
  logic [31:0]      if_id_instr;
  logic [31:0]      if_id_pc4;
  logic             if_id_valid;
  logic             redirect;
  logic [CNT_W-1:0] redirect_cnt;

  // Fetch unit side: owns the PC and the IF/ID register.
  modport master (
    input  stall, zero, imem_instr,
    output pc, if_id_instr, if_id_pc4, if_id_valid, redirect, redirect_cnt
  );

  // Environment side: hazard unit, comparator and instruction memory.
  modport slave (
    output stall, zero, imem_instr,
    input  pc, if_id_instr, if_id_pc4, if_id_valid, redirect, redirect_cnt
  );
endinterface

// File: rtl/fetch_redirect_unit.sv
// Fetch-stage PC register and IF/ID register. Resolves beq/bne/j held in
// IF/ID, redirects fetch with a single bubble, honours stall, counts redirects.
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_redirect_unit_if.master bus
);

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc4_q, pc4_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [5:0]  opcode;
  logic        is_jump;
  logic        is_branch;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  // PC-relative target: word offset is sign-extended, wraps modulo 2^32.
  function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                input logic [15:0] imm);
    logic signed [31:0] offset;
    offset = signed'({{14{imm[15]}}, imm, 2'b00});
    return pc4 + unsigned'(offset);
  endfunction

  // Pseudo-direct target: region bits come from the delay-slot-free PC+4.
  function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                              input logic [25:0] idx);
    return {pc4[31:28], idx, 2'b00};
  endfunction

  assign pc_plus4 = pc_q + 32'd4;

  // Decode the IF/ID instruction; zero only matters for beq/bne.
  always_comb begin
    opcode    = instr_q[31:26];
    is_jump   = (opcode == OP_J);
    is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
    redirect  = valid_q & (is_jump | (is_branch & bus.zero));
    target    = is_jump ? jump_target(pc4_q, instr_q[25:0])
                        : branch_target(pc4_q, instr_q[15:0]);
  end

  // Next state: stall holds everything, redirect flushes, else fetch in order.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (!bus.stall) begin
      if (redirect) begin
        pc_d    = target;
        instr_d = '0;
        pc4_d   = '0;
        valid_d = 1'b0;
        cnt_d   = cnt_q + CNT_W'(1);
      end else begin
        pc_d    = pc_plus4;
        instr_d = bus.imem_instr;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset overriding all else.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.if_id_instr  = instr_q;
  assign bus.if_id_pc4    = pc4_q;
  assign bus.if_id_valid  = valid_q;
  assign bus.redirect     = redirect;
  assign bus.redirect_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Bench for fetch_redirect_unit: two instances (16-bit counter at PC 0, and a
// 2-bit counter at PC A000_0000) share one stimulus stream and are compared
// every cycle against a behavioural model, plus directed literal expectations.
module tb_fetch_redirect_unit;

  localparam logic [31:0] RPC1  = 32'hA000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] BEQ3  = 32'h1000_0003;
  localparam logic [31:0] BNEM2 = 32'h1400_FFFE;
  localparam logic [31:0] ADD   = 32'h012A_4020;
  localparam logic [31:0] J40   = 32'h0800_0040;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        zero;
  logic [31:0] imem;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_redirect_unit_if #(.CNT_W(16)) bus0 ();
  fetch_redirect_unit_if #(.CNT_W(2))  bus1 ();

  assign bus0.stall      = stall;
  assign bus0.zero       = zero;
  assign bus0.imem_instr = imem;
  assign bus1.stall      = stall;
  assign bus1.zero       = zero;
  assign bus1.imem_instr = imem;

  fetch_redirect_unit #(.RESET_PC(32'h0), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  fetch_redirect_unit #(.RESET_PC(RPC1), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  logic [31:0] d_pc[2], d_instr[2], d_pc4[2], d_cnt[2];
  logic        d_valid[2], d_redir[2];
  assign d_pc[0] = bus0.pc;          assign d_pc[1] = bus1.pc;
  assign d_instr[0] = bus0.if_id_instr; assign d_instr[1] = bus1.if_id_instr;
  assign d_pc4[0] = bus0.if_id_pc4;  assign d_pc4[1] = bus1.if_id_pc4;
  assign d_valid[0] = bus0.if_id_valid; assign d_valid[1] = bus1.if_id_valid;
  assign d_redir[0] = bus0.redirect; assign d_redir[1] = bus1.redirect;
  assign d_cnt[0] = 32'(bus0.redirect_cnt);
  assign d_cnt[1] = 32'(bus1.redirect_cnt);

  // Behavioural model: architectural view of the fetch stage.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] cnt;
  } mstate_t;

  mstate_t m[2];
  bit      m_ok = 1'b0;

  function automatic logic [31:0] reset_pc(input int i);
    return (i == 0) ? 32'h0 : RPC1;
  endfunction

  function automatic logic [31:0] cnt_mask(input int i);
    return (i == 0) ? 32'h0000_FFFF : 32'h0000_0003;
  endfunction

  function automatic bit m_redirect(input mstate_t s, input logic z);
    int op;
    op = int'(s.instr[31:26]);
    if (!s.valid) return 1'b0;
    if (op == 2) return 1'b1;
    if ((op == 4 || op == 5) && z) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_target(input mstate_t s);
    int off;
    if (s.instr[31:26] == 6'd2) return {s.pc4[31:28], s.instr[25:0], 2'b00};
    off = int'($signed(s.instr[15:0])) * 4;
    return s.pc4 + 32'(off);
  endfunction

  function automatic mstate_t m_next(input mstate_t s, input int i,
                                     input logic r, input logic st,
                                     input logic z, input logic [31:0] im);
    mstate_t n;
    n = s;
    if (!r) begin
      n.pc = reset_pc(i); n.instr = 0; n.pc4 = 0; n.valid = 0; n.cnt = 0;
    end else if (st) begin
      n = s;
    end else if (m_redirect(s, z)) begin
      n.pc = m_target(s); n.instr = 0; n.pc4 = 0; n.valid = 0;
      n.cnt = s.cnt + 1;
    end else begin
      n.pc4 = s.pc + 4; n.pc = s.pc + 4; n.instr = im; n.valid = 1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) m[i] <= m_next(m[i], i, rst, stall, zero, imem);
    m_ok <= m_ok | ~rst;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_ok) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("model_pc%0d", i), d_pc[i], m[i].pc);
        check($sformatf("model_instr%0d", i), d_instr[i], m[i].instr);
        check($sformatf("model_pc4_%0d", i), d_pc4[i], m[i].pc4);
        check($sformatf("model_valid%0d", i), 32'(d_valid[i]), 32'(m[i].valid));
        check($sformatf("model_redirect%0d", i), 32'(d_redir[i]),
              32'(m_redirect(m[i], zero)));
        check($sformatf("model_cnt%0d", i), d_cnt[i], m[i].cnt & cnt_mask(i));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0: r[31:26] = 6'b000100;
      1: r[31:26] = 6'b000101;
      2: r[31:26] = 6'b000010;
      3: r[31:26] = 6'b000000;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    rst = 1'b0; stall = 1'b0; zero = 1'b0; imem = NOP;
    tick(); tick();
    check("rst_pc0", d_pc[0], 32'h0);
    check("rst_pc1", d_pc[1], RPC1);
    check("rst_valid", 32'(d_valid[0]), 32'd0);
    check("rst_instr", d_instr[0], 32'h0);
    check("rst_pc4", d_pc4[0], 32'h0);
    check("rst_cnt", d_cnt[0], 32'd0);
    check("rst_redirect", 32'(d_redir[0]), 32'd0);

    // Sequential fetch of nops.
    rst = 1'b1;
    tick();
    check("seq_pc_4", d_pc[0], 32'h4);
    check("seq_pc4_4", d_pc4[0], 32'h4);
    check("seq_valid", 32'(d_valid[0]), 32'd1);
    tick();
    check("seq_pc_8", d_pc[0], 32'h8);
    check("seq_pc4_8", d_pc4[0], 32'h8);
    tick();
    check("seq_pc_12", d_pc[0], 32'hC);
    check("seq_pc4_12", d_pc4[0], 32'hC);

    // beq taken, imm 3, pc4 0x10.
    imem = BEQ3;
    tick();
    check("beq_pc4", d_pc4[0], 32'h10);
    zero = 1'b1; imem = 32'hDEAD_BEEF;
    #1 check("beq_redirect", 32'(d_redir[0]), 32'd1);
    tick();
    check("beq_pc", d_pc[0], 32'h1C);
    check("beq_valid", 32'(d_valid[0]), 32'd0);
    check("beq_cnt", d_cnt[0], 32'd1);
    check("beq_flush", d_instr[0], 32'h0);
    zero = 1'b0;

    // bne with negative offset, not taken.
    imem = BNEM2;
    tick();
    #1 check("bne_redirect", 32'(d_redir[0]), 32'd0);
    imem = NOP;
    tick();
    check("bne_pc", d_pc[0], 32'h24);
    check("bne_valid", 32'(d_valid[0]), 32'd1);

    // Non-branch opcode ignores zero.
    imem = ADD;
    tick();
    zero = 1'b1;
    #1 check("add_redirect", 32'(d_redir[0]), 32'd0);
    imem = NOP;
    tick();
    check("add_pc", d_pc[0], 32'h2C);
    zero = 1'b0;

    // Jump to word 0x40 within the current region.
    imem = J40;
    tick();
    check("j_redirect", 32'(d_redir[0]), 32'd1);
    imem = 32'hBADC_0DE0;
    tick();
    check("j_pc0", d_pc[0], 32'h100);
    check("j_pc1", d_pc[1], 32'hA000_0100);
    check("j_valid", 32'(d_valid[0]), 32'd0);
    check("j_cnt", d_cnt[0], 32'd2);
    imem = NOP;
    tick();
    check("j_after_valid", 32'(d_valid[0]), 32'd1);
    check("j_after_pc4", d_pc4[0], 32'h104);

    // Taken beq held by a 3-cycle stall.
    imem = BEQ3;
    tick();
    zero = 1'b1; stall = 1'b1; imem = 32'h1234_5678;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_pc", d_pc[0], 32'h108);
      check("stall_pc4", d_pc4[0], 32'h108);
      check("stall_cnt", d_cnt[0], 32'd2);
      check("stall_redirect", 32'(d_redir[0]), 32'd1);
    end
    stall = 1'b0;
    tick();
    check("stall_release_pc", d_pc[0], 32'h114);
    check("stall_release_cnt", d_cnt[0], 32'd3);
    check("stall_release_valid", 32'(d_valid[0]), 32'd0);
    zero = 1'b0;

    // Reset on the same edge as a redirect.
    imem = BEQ3;
    tick();
    zero = 1'b1; rst = 1'b0;
    tick();
    check("rstmid_pc0", d_pc[0], 32'h0);
    check("rstmid_pc1", d_pc[1], RPC1);
    check("rstmid_cnt", d_cnt[0], 32'd0);
    check("rstmid_valid", 32'(d_valid[0]), 32'd0);
    rst = 1'b1; zero = 1'b0;

    // Five redirects: 2-bit counter wraps to 1.
    for (int r = 0; r < 5; r++) begin
      imem = J40;
      tick();
      imem = NOP;
      tick();
    end
    check("wrap_cnt16", d_cnt[0], 32'd5);
    check("wrap_cnt2", d_cnt[1], 32'd1);

    // Randomized traffic, compared every cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 99) != 0);
      stall = ($urandom_range(0, 4) == 0);
      zero  = $urandom_range(0, 1) == 1;
      imem  = rand_instr();
      tick();
    end
    rst = 1'b1; stall = 1'b0; zero = 1'b0; imem = NOP;
    tick();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
